// File: rtl/mig_burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mig_burst_pkg
//  Description : Shared types and command encodings for the MIG burst engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package mig_burst_pkg;

  // Engine control states
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  // MIG UI command encodings
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, head driven from storage registers,
//                occupancy count and full/empty flags. A push while full is
//                accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import mig_burst_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; storage itself needs no reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Data storage write port
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mig_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mig_burst_engine
//  Description : MIG 7-series UI master issuing read/write bursts of
//                0..2^LEN_W-1 beats; read data returns through a FIFO whose
//                free space is reserved before each read command is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module mig_burst_engine
  import mig_burst_pkg::*;
#(
  parameter int DATA_W        = 256,
  parameter int ADDR_W        = 29,
  parameter int LEN_W         = 6,
  parameter int ADDR_STEP     = 8,
  parameter int RD_FIFO_DEPTH = 16
) (
  input  logic                ui_clk,
  input  logic                sys_rst,
  input  logic                init_calib_complete,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  output logic                busy,
  output logic                done,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_overflow,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;
  localparam int SUM_W = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   cmd_cnt;
  logic [LEN_W-1:0]   dat_cnt;
  logic [LEN_W-1:0]   ret_cnt;
  logic [ADDR_W-1:0]  addr_base;
  logic               zero_done;
  logic               overflow;
  logic               req_fire;
  logic               cmd_fire;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEN_W-1:0]   outstanding;
  logic [SUM_W-1:0]   credit_used;

  assign req_fire     = req_valid && (state == ST_IDLE);
  assign cmd_fire     = app_en && app_rdy;
  assign app_wdf_data = wr_data;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;
  assign rd_valid     = !fifo_empty;
  assign rd_overflow  = overflow;

  // Beat address depends only on latched base and command count, so it
  // stays stable while a command waits for app_rdy.
  assign app_addr = addr_base + ADDR_W'(cmd_cnt) * ADDR_W'(ADDR_STEP);

  // Read credit: commands in flight plus beats already parked in the FIFO
  assign outstanding = cmd_cnt - ret_cnt;
  assign credit_used = SUM_W'(outstanding) + SUM_W'(fifo_count);

  // State register
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) state <= ST_INIT;
    else          state <= state_nxt;
  end

  // Next-state logic; a zero-length request never leaves IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (init_calib_complete) state_nxt = ST_IDLE;
      ST_IDLE:  if (req_fire && (req_len != '0)) state_nxt = req_write ? ST_WRITE : ST_READ;
      ST_WRITE: if ((cmd_cnt == len) && (dat_cnt == len)) state_nxt = ST_IDLE;
      ST_READ:  if (ret_cnt == len) state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // Output decode; a write command is only offered once its data is in
  always_comb begin
    req_ready    = 1'b0;
    busy         = 1'b0;
    wr_ready     = 1'b0;
    app_wdf_wren = 1'b0;
    app_en       = 1'b0;
    app_cmd      = CMD_WRITE;
    done         = zero_done;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_WRITE: begin
        busy         = 1'b1;
        wr_ready     = app_wdf_rdy && (dat_cnt < len);
        app_wdf_wren = wr_valid && wr_ready;
        app_en       = (cmd_cnt < len) && ((dat_cnt > cmd_cnt) || app_wdf_wren);
        done         = (cmd_cnt == len) && (dat_cnt == len);
      end
      ST_READ: begin
        busy    = 1'b1;
        app_cmd = CMD_READ;
        app_en  = (cmd_cnt < len) && (credit_used < SUM_W'(RD_FIFO_DEPTH));
        done    = (ret_cnt == len);
      end
      default: ;
    endcase
  end

  // Burst bookkeeping: latch request, count commands, data beats and returns
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      len       <= '0;
      addr_base <= '0;
      cmd_cnt   <= '0;
      dat_cnt   <= '0;
      ret_cnt   <= '0;
      zero_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      zero_done <= req_fire && (req_len == '0);
      if (req_fire) begin
        len       <= req_len;
        addr_base <= req_addr;
        cmd_cnt   <= '0;
        dat_cnt   <= '0;
        ret_cnt   <= '0;
      end else begin
        if (cmd_fire)          cmd_cnt <= cmd_cnt + LEN_W'(1);
        if (app_wdf_wren)      dat_cnt <= dat_cnt + LEN_W'(1);
        if (app_rd_data_valid) ret_cnt <= ret_cnt + LEN_W'(1);
      end
      if (app_rd_data_valid && fifo_full && !rd_ready) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (ui_clk),
    .rst_n     (sys_rst),
    .push      (app_rd_data_valid),
    .push_data (app_rd_data),
    .pop       (rd_ready),
    .head      (rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_mig_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mig_burst_engine
//  Description : Scoreboard bench for mig_burst_engine with a simple MIG
//                model returning read data (address/8) 10 cycles after each
//                accepted read command.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mig_burst_engine;
  import mig_burst_pkg::*;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 29;
  localparam int LEN_W  = 6;
  localparam int DEPTH  = 16;

  logic                ui_clk;
  logic                sys_rst;
  logic                init_calib_complete;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [LEN_W-1:0]    req_len;
  logic                busy;
  logic                done;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_valid;
  logic                wr_ready;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic                rd_overflow;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_rdy;
  logic [DATA_W-1:0]   app_rd_data;
  logic                app_rd_data_valid;

  mig_burst_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ADDR_STEP(8), .RD_FIFO_DEPTH(DEPTH)
  ) dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .busy(busy), .done(done),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_overflow(rd_overflow),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  cmd_t              exp_cmd[$];
  logic [DATA_W-1:0] exp_wd[$];
  logic [DATA_W-1:0] exp_rd[$];
  int                rsp_due[$];
  logic [DATA_W-1:0] rsp_dat[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int en_cycles = 0;
  int wr_beats = 0;
  int wr_cmds = 0;
  int rd_cmds = 0;
  int rd_pops = 0;
  logic toggle_rdy = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- MIG model: app_rdy pattern and delayed read return
  initial begin
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(negedge ui_clk);
      cyc++;
      app_rdy = toggle_rdy ? ~app_rdy : 1'b1;
      if (sys_rst && rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = rsp_dat.pop_front();
        rsp_due.delete(0);
      end else begin
        app_rd_data_valid = 1'b0;
      end
    end
  end

  // ---------------- Monitor: pops expectations whenever the DUT presents data
  initial begin
    cmd_t c;
    logic hold_pend;
    logic [ADDR_W-1:0] hold_addr;
    logic [2:0] hold_cmd;
    hold_pend = 1'b0;
    hold_addr = '0;
    hold_cmd = '0;
    forever begin
      @(negedge ui_clk);
      #4;
      if (!sys_rst) begin
        hold_pend = 1'b0;
        rd_cmds = 0;
        rd_pops = 0;
        rsp_due.delete();
        rsp_dat.delete();
        continue;
      end
      if (hold_pend) begin
        chk("cmd_hold_en", app_en, 1'b1);
        chk("cmd_hold_addr", app_addr, hold_addr);
        chk("cmd_hold_cmd", app_cmd, hold_cmd);
      end
      hold_pend = app_en && !app_rdy;
      hold_addr = app_addr;
      hold_cmd = app_cmd;
      if (app_en) en_cycles++;
      if (app_en && app_cmd == CMD_WRITE)
        chk("cmd_after_data", (wr_beats + int'(app_wdf_wren)) > wr_cmds, 1'b1);
      if (app_wdf_wren) begin
        if (exp_wd.size() == 0) chk("wdata_unexpected", 1'b1, 1'b0);
        else chk("wdata", app_wdf_data, exp_wd.pop_front());
        chk("wdf_end", app_wdf_end, 1'b1);
        chk("wdf_mask", app_wdf_mask, '0);
        wr_beats++;
      end
      if (app_en && app_rdy) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", 1'b1, 1'b0);
        else begin
          c = exp_cmd.pop_front();
          chk("cmd_addr", app_addr, c.addr);
          chk("cmd_type", app_cmd, c.cmd);
        end
        if (app_cmd == CMD_WRITE) wr_cmds++;
        else begin
          rd_cmds++;
          rsp_due.push_back(cyc + 10);
          rsp_dat.push_back(DATA_W'(app_addr >> 3));
          chk("read_credit", (rd_cmds - rd_pops) <= DEPTH, 1'b1);
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk("rdata_unexpected", 1'b1, 1'b0);
        else chk("rdata", rd_data, exp_rd.pop_front());
        rd_pops++;
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- Stimulus helpers
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_overflow"}, rd_overflow, 1'b0);
    chk({tag, "_app_en"}, app_en, 1'b0);
    chk({tag, "_wdf_wren"}, app_wdf_wren, 1'b0);
    chk({tag, "_app_cmd"}, app_cmd, 3'b000);
    chk({tag, "_app_addr"}, app_addr, '0);
  endtask

  task automatic issue_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    int t;
    @(negedge ui_clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_len = l;
    #4;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge ui_clk);
      #4;
      t++;
    end
    chk("req_accept", req_ready, 1'b1);
    @(negedge ui_clk);
    req_valid = 1'b0;
  endtask

  task automatic send_wdata(input int n, input int base);
    int k;
    int t;
    k = 0;
    t = 0;
    while (k < n && t < 500) begin
      @(negedge ui_clk);
      wr_valid = 1'b1;
      wr_data = DATA_W'(base + k);
      #4;
      if (wr_ready) k++;
      t++;
    end
    @(negedge ui_clk);
    wr_valid = 1'b0;
    chk("wdata_sent", k, n);
  endtask

  task automatic wait_done(input int d0, input int limit);
    int t;
    t = 0;
    while ((done_cnt == d0 || exp_cmd.size() != 0 || exp_wd.size() != 0 || exp_rd.size() != 0)
           && t < limit) begin
      @(negedge ui_clk);
      t++;
    end
    chk("burst_finished", t < limit, 1'b1);
    repeat (3) @(negedge ui_clk);
    chk("done_once", done_cnt - d0, 1);
  endtask

  // ---------------- Directed test sequence
  initial begin
    int d0;
    int e0;
    int w0;
    int c0;
    sys_rst = 1'b0;
    init_calib_complete = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_len = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_ready = 1'b0;

    repeat (3) @(negedge ui_clk);
    #1;
    check_reset_outputs("reset");
    sys_rst = 1'b1;

    // Calibration pending: nothing may move
    for (int i = 0; i < 100; i++) begin
      @(negedge ui_clk);
      #4;
      chk("init_req_ready", req_ready, 1'b0);
      chk("init_app_en", app_en, 1'b0);
    end
    @(negedge ui_clk);
    init_calib_complete = 1'b1;
    @(negedge ui_clk);
    #1;
    chk("calib_req_ready", req_ready, 1'b1);

    // Write 4 beats at 0x100
    for (int i = 0; i < 4; i++) begin
      exp_cmd.push_back('{CMD_WRITE, ADDR_W'(32'h100 + 8 * i)});
      exp_wd.push_back(DATA_W'(8'hA0 + i));
    end
    d0 = done_cnt; w0 = wr_beats; c0 = wr_cmds;
    issue_req(1'b1, 29'h100, 6'd4);
    send_wdata(4, 'hA0);
    wait_done(d0, 200);
    chk("wr4_beats", wr_beats - w0, 4);
    chk("wr4_cmds", wr_cmds - c0, 4);

    // Write 3 beats with app_rdy toggling
    toggle_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_cmd.push_back('{CMD_WRITE, ADDR_W'(32'h2000 + 8 * i)});
      exp_wd.push_back(DATA_W'(8'hB0 + i));
    end
    d0 = done_cnt; w0 = wr_beats; c0 = wr_cmds;
    issue_req(1'b1, 29'h2000, 6'd3);
    send_wdata(3, 'hB0);
    wait_done(d0, 200);
    chk("wr3_beats", wr_beats - w0, 3);
    chk("wr3_cmds", wr_cmds - c0, 3);
    toggle_rdy = 1'b0;

    // Read 40 beats with consumer stalled
    for (int i = 0; i < 40; i++) begin
      exp_cmd.push_back('{CMD_READ, ADDR_W'(8 * i)});
      exp_rd.push_back(DATA_W'(i));
    end
    d0 = done_cnt;
    issue_req(1'b0, 29'h0, 6'd40);
    repeat (80) @(negedge ui_clk);
    #4;
    chk("rd_stall_cmds", rd_cmds, 16);
    chk("rd_stall_valid", rd_valid, 1'b1);
    chk("rd_stall_overflow", rd_overflow, 1'b0);
    @(negedge ui_clk);
    rd_ready = 1'b1;
    wait_done(d0, 2000);
    chk("rd40_overflow", rd_overflow, 1'b0);

    // Address wrap across the top of the address space
    exp_cmd.push_back('{CMD_READ, 29'h1FFFFFF8});
    exp_cmd.push_back('{CMD_READ, 29'h0});
    exp_rd.push_back(DATA_W'(32'h03FFFFFF));
    exp_rd.push_back(DATA_W'(0));
    d0 = done_cnt;
    issue_req(1'b0, 29'h1FFFFFF8, 6'd2);
    wait_done(d0, 200);

    // Zero-length request
    d0 = done_cnt; e0 = en_cycles;
    issue_req(1'b1, 29'h40, 6'd0);
    #1;
    chk("len0_done_pulse", done, 1'b1);
    chk("len0_busy", busy, 1'b0);
    @(negedge ui_clk);
    #1;
    chk("len0_done_low", done, 1'b0);
    repeat (5) @(negedge ui_clk);
    chk("len0_done_count", done_cnt - d0, 1);
    chk("len0_no_app_en", en_cycles - e0, 0);

    // Reset in the middle of a read burst
    rd_ready = 1'b0;
    for (int i = 0; i < 40; i++) exp_cmd.push_back('{CMD_READ, ADDR_W'(32'h400 + 8 * i)});
    d0 = done_cnt;
    issue_req(1'b0, 29'h400, 6'd40);
    repeat (30) @(negedge ui_clk);
    #1;
    chk("midread_fifo_busy", rd_valid, 1'b1);
    @(negedge ui_clk);
    sys_rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_cmd.delete();
    repeat (5) @(negedge ui_clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    sys_rst = 1'b1;
    @(negedge ui_clk);
    #1;
    chk("post_rst_ready", req_ready, 1'b1);

    // FIFO must come back empty: first data is the new burst's
    rd_ready = 1'b1;
    exp_cmd.push_back('{CMD_READ, 29'h80});
    exp_cmd.push_back('{CMD_READ, 29'h88});
    exp_rd.push_back(DATA_W'(32'h10));
    exp_rd.push_back(DATA_W'(32'h11));
    d0 = done_cnt;
    issue_req(1'b0, 29'h80, 6'd2);
    wait_done(d0, 200);

    chk("final_overflow", rd_overflow, 1'b0);
    chk("final_rd_valid", rd_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
